// File: rtl/eightbit_alu_ctrl_if.sv
// Command/response handshake bundle between an instruction source (master)
// and the eightbit_alu_ctrl sequencer (slave).
interface eightbit_alu_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_srca;
  logic [1:0] cmd_srcb;
  logic [7:0] cmd_imm;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_ovf;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
  );
endinterface

// File: rtl/eightbit_alu_ctrl.sv
// Multi-cycle sequencer driving an external combinational 8-bit ALU from a 4x8 register file.
// Optional feature: define ALU_CTRL_SAT_EN to saturate ADD results to 8'hFF on carry-out.
module eightbit_alu_ctrl (
  input  logic                     clk,
  input  logic                     rst_n,
  eightbit_alu_ctrl_if.slave       bus,
  output logic [1:0]               alu_sel,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  input  logic [7:0]               alu_f,
  input  logic                     alu_ovf,
  input  logic [1:0]               dbg_addr,
  output logic [7:0]               dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd4;

`ifdef ALU_CTRL_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [1:0] dst_q, dst_d;
  logic [1:0] srca_q, srca_d;
  logic [1:0] srcb_q, srcb_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] rf_q [4];
  logic [7:0] rf_d [4];
  logic [1:0] alu_sel_q, alu_sel_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_ovf_q, rsp_ovf_d;
  logic       rsp_err_q, rsp_err_d;
  logic [7:0] exec_result;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      dst_q      <= '0;
      srca_q     <= '0;
      srcb_q     <= '0;
      imm_q      <= '0;
      // NOTE: the register file is explicitly cleared on reset because software
      // relies on R0-R3 reading zero; a plain RAM here would come up undefined.
      rf_q       <= '{default: '0};
      alu_sel_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      srca_q     <= srca_d;
      srcb_q     <= srcb_d;
      imm_q      <= imm_d;
      rf_q       <= rf_d;
      alu_sel_q  <= alu_sel_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    imm_d       = imm_q;
    rf_d        = rf_q;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    exec_result = alu_f;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          dst_d   = bus.cmd_dst;
          srca_d  = bus.cmd_srca;
          srcb_d  = bus.cmd_srcb;
          imm_d   = bus.cmd_imm;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        alu_sel_d = op_q[1:0];
        alu_a_d   = rf_q[srca_q];
        alu_b_d   = rf_q[srcb_q];
        if (!op_q[2]) begin
          state_d = S_EXEC;
        end else begin
          // LDI and illegal ops never touch the ALU; their response is set up here.
          state_d   = S_WB;
          rsp_ovf_d = 1'b0;
          if (op_q == OP_LDI) begin
            rf_d[dst_q] = imm_q;
            rsp_data_d  = imm_q;
            rsp_err_d   = 1'b0;
          end else begin
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end
        end
      end

      S_EXEC: begin
        if (SatEn && (op_q == OP_ADD) && alu_ovf) begin
          exec_result = 8'hFF;
        end
        rf_d[dst_q] = exec_result;
        rsp_data_d  = exec_result;
        rsp_ovf_d   = alu_ovf;
        rsp_err_d   = 1'b0;
        state_d     = S_WB;
      end

      S_WB: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_WB);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_err   = rsp_err_q;

  assign alu_sel  = alu_sel_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_eightbit_alu_ctrl.sv
// Directed bench for eightbit_alu_ctrl: table of command vectors plus stall and
// mid-operation reset sequences, with a behavioural model of the external ALU.
module tb_eightbit_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] alu_sel;
  logic [7:0] alu_a, alu_b, alu_f;
  logic       alu_ovf;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  eightbit_alu_ctrl_if bus ();

  eightbit_alu_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .alu_sel  (alu_sel),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_f    (alu_f),
    .alu_ovf  (alu_ovf),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // External ALU: ADD, NOT-B, AND, OR.
  always_comb begin
    alu_f   = '0;
    alu_ovf = 1'b0;
    case (alu_sel)
      2'd0:    {alu_ovf, alu_f} = {1'b0, alu_a} + {1'b0, alu_b};
      2'd1:    alu_f = ~alu_b;
      2'd2:    alu_f = alu_a & alu_b;
      default: alu_f = alu_a | alu_b;
    endcase
  end

`ifdef ALU_CTRL_SAT_EN
  localparam logic [7:0] OVF_SUM = 8'hFF;
`else
  localparam logic [7:0] OVF_SUM = 8'h00;
`endif

  typedef struct {
    logic [2:0] op;
    logic [1:0] dst, sa, sb;
    logic [7:0] imm;
    logic [7:0] e_data;
    logic       e_ovf, e_err;
    int         e_lat;
    logic [1:0] e_sel;
    logic [7:0] e_a, e_b;
    logic [7:0] e_dbg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] op, logic [1:0] dst, logic [1:0] sa, logic [1:0] sb,
                              logic [7:0] imm, logic [7:0] e_data, logic e_ovf, logic e_err,
                              int e_lat, logic [1:0] e_sel, logic [7:0] e_a, logic [7:0] e_b,
                              logic [7:0] e_dbg);
    vec_t v;
    v.op = op; v.dst = dst; v.sa = sa; v.sb = sb; v.imm = imm;
    v.e_data = e_data; v.e_ovf = e_ovf; v.e_err = e_err; v.e_lat = e_lat;
    v.e_sel = e_sel; v.e_a = e_a; v.e_b = e_b; v.e_dbg = e_dbg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Issues one command at a negedge; returns with the bench at the negedge
  // where rsp_valid is first seen (or after a bounded wait).
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [7:0] imm,
                         output int lat, output logic busy_ready,
                         output logic [1:0] sel, output logic [7:0] a, output logic [7:0] b);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_dst   = dst;
    bus.cmd_srca  = sa;
    bus.cmd_srcb  = sb;
    bus.cmd_imm   = imm;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    busy_ready    = bus.cmd_ready;
    lat = 1;
    sel = '0; a = '0; b = '0;
    while (!bus.rsp_valid && lat < 10) begin
      sel = alu_sel; a = alu_a; b = alu_b;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_dbg(input string name, input logic [1:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    check(name, dbg_data, exp);
  endtask

  int         lat;
  logic       busy_ready;
  logic [1:0] sel;
  logic [7:0] a, b;

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_dst   = '0;
    bus.cmd_srca  = '0;
    bus.cmd_srcb  = '0;
    bus.cmd_imm   = '0;
    bus.rsp_ready = 1'b1;
    dbg_addr      = '0;

    vecs.push_back(mk(3'd4, 2'd1, 2'd0, 2'd0, 8'h54, 8'h54, 1'b0, 1'b0, 2, 2'd0, 8'h00, 8'h00, 8'h54));
    vecs.push_back(mk(3'd4, 2'd2, 2'd0, 2'd0, 8'hAA, 8'hAA, 1'b0, 1'b0, 2, 2'd0, 8'h00, 8'h00, 8'hAA));
    vecs.push_back(mk(3'd0, 2'd3, 2'd1, 2'd2, 8'h00, 8'hFE, 1'b0, 1'b0, 3, 2'd0, 8'h54, 8'hAA, 8'hFE));
    vecs.push_back(mk(3'd4, 2'd0, 2'd0, 2'd0, 8'hAB, 8'hAB, 1'b0, 1'b0, 2, 2'd0, 8'h00, 8'h00, 8'hAB));
    vecs.push_back(mk(3'd4, 2'd1, 2'd0, 2'd0, 8'h55, 8'h55, 1'b0, 1'b0, 2, 2'd0, 8'h00, 8'h00, 8'h55));
    vecs.push_back(mk(3'd0, 2'd0, 2'd0, 2'd1, 8'h00, OVF_SUM, 1'b1, 1'b0, 3, 2'd0, 8'hAB, 8'h55, OVF_SUM));
    vecs.push_back(mk(3'd1, 2'd3, 2'd1, 2'd2, 8'h00, 8'h55, 1'b0, 1'b0, 3, 2'd1, 8'h55, 8'hAA, 8'h55));
    vecs.push_back(mk(3'd2, 2'd3, 2'd1, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0, 3, 2'd2, 8'h55, 8'hAA, 8'h00));
    vecs.push_back(mk(3'd3, 2'd3, 2'd1, 2'd2, 8'h00, 8'hFF, 1'b0, 1'b0, 3, 2'd3, 8'h55, 8'hAA, 8'hFF));
    vecs.push_back(mk(3'd4, 2'd2, 2'd0, 2'd0, 8'h12, 8'h12, 1'b0, 1'b0, 2, 2'd0, 8'h00, 8'h00, 8'h12));
    vecs.push_back(mk(3'd6, 2'd2, 2'd1, 2'd1, 8'h00, 8'h00, 1'b0, 1'b1, 2, 2'd0, 8'h00, 8'h00, 8'h12));
    vecs.push_back(mk(3'd7, 2'd1, 2'd0, 2'd0, 8'h99, 8'h00, 1'b0, 1'b1, 2, 2'd0, 8'h00, 8'h00, 8'h55));
    vecs.push_back(mk(3'd0, 2'd1, 2'd1, 2'd1, 8'h00, 8'hAA, 1'b0, 1'b0, 3, 2'd0, 8'h55, 8'h55, 8'hAA));

    // Reset: two edges with rst_n low.
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data",  bus.rsp_data, 0);
    check("rst_rsp_ovf",   bus.rsp_ovf, 0);
    check("rst_rsp_err",   bus.rsp_err, 0);
    check("rst_alu_sel",   alu_sel, 0);
    check("rst_alu_a",     alu_a, 0);
    check("rst_alu_b",     alu_b, 0);
    for (int r = 0; r < 4; r++) check_dbg($sformatf("rst_dbg%0d", r), 2'(r), 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].dst, vecs[i].sa, vecs[i].sb, vecs[i].imm, lat, busy_ready, sel, a, b);
      check($sformatf("v%0d_latency", i),   lat, vecs[i].e_lat);
      check($sformatf("v%0d_busy_ready", i), busy_ready, 0);
      check($sformatf("v%0d_data", i),      bus.rsp_data, vecs[i].e_data);
      check($sformatf("v%0d_ovf", i),       bus.rsp_ovf, vecs[i].e_ovf);
      check($sformatf("v%0d_err", i),       bus.rsp_err, vecs[i].e_err);
      if (vecs[i].e_lat == 3) begin
        check($sformatf("v%0d_exec_sel", i), sel, vecs[i].e_sel);
        check($sformatf("v%0d_exec_a", i),   a, vecs[i].e_a);
        check($sformatf("v%0d_exec_b", i),   b, vecs[i].e_b);
      end
      @(negedge clk);
      check($sformatf("v%0d_rsp_valid_drop", i), bus.rsp_valid, 0);
      check($sformatf("v%0d_ready_back", i),     bus.cmd_ready, 1);
      check_dbg($sformatf("v%0d_dbg", i), vecs[i].dst, vecs[i].e_dbg);
    end

    // Back-pressure: R3 = R1 + R2 = AA + 12 with rsp_ready low for 5 cycles.
    bus.rsp_ready = 1'b0;
    run_cmd(3'd0, 2'd3, 2'd1, 2'd2, 8'h00, lat, busy_ready, sel, a, b);
    check("stall_latency", lat, 3);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_valid", k), bus.rsp_valid, 1);
      check($sformatf("stall%0d_data", k),  bus.rsp_data, 8'hBC);
      check($sformatf("stall%0d_ovf", k),   bus.rsp_ovf, 0);
      check($sformatf("stall%0d_ready", k), bus.cmd_ready, 0);
      check_dbg($sformatf("stall%0d_dbg", k), 2'd3, 8'hBC);
      if (k == 2) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd4;
        bus.cmd_dst   = 2'd3;
        bus.cmd_imm   = 8'h77;
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", bus.rsp_valid, 0);
    check("stall_release_ready", bus.cmd_ready, 1);
    @(negedge clk);
    check("stall_no_queued_cmd", bus.cmd_ready, 1);
    check_dbg("stall_r3_final", 2'd3, 8'hBC);

    // Reset while an ADD sits in EXEC: command abandoned, register file cleared.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd0;
    bus.cmd_dst   = 2'd0;
    bus.cmd_srca  = 2'd1;
    bus.cmd_srcb  = 2'd2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_exec_a", alu_a, 8'hAA);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready", bus.cmd_ready, 1);
    check("abort_alu_a", alu_a, 0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort%0d_no_rsp", k), bus.rsp_valid, 0);
      @(negedge clk);
    end
    for (int r = 0; r < 4; r++) check_dbg($sformatf("abort_dbg%0d", r), 2'(r), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
